serial_adder: RTL and testbench
===============================

// Module: serial_adder
// PURPOSE
// Parametrised multi-cycle adder/subtractor. Computes a WIDTH-bit sum or difference by
//   processing SLICE bits per clock through a registered carry chain.
// Trades latency for area against the single-cycle full-adder chains in this lab series.
// Sits behind a start/busy/done handshake so a controller FSM can issue operations.
// PARAMETERS
// WIDTH  8  operand/result width in bits; must be >= 2
// SLICE  1  bits added per clock; WIDTH % SLICE must be 0; NSL = WIDTH/SLICE cycles per op
// PORTS
// clk    in   1      single clock, all state updates on rising edge
// rst    in   1      synchronous, active-high reset
// start  in   1      request; sampled only in IDLE
// sub    in   1      0: a+b+c_in   1: a-b-c_in (c_in acts as borrow-in)
// a      in   WIDTH  operand A, latched on accepted start
// b      in   WIDTH  operand B, latched on accepted start
// c_in   in   1      carry/borrow in, latched on accepted start
// busy   out  1      high while an operation is in progress
// done   out  1      one-cycle pulse: results just updated
// s      out  WIDTH  result; registered, held until the next completion
// c_out  out  1      raw carry out of MSB (sub mode: 1 = no borrow)
// ovf    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
// - Reset (rst=1 at an edge): state=IDLE, busy=0, done=0, s=0, c_out=0, ovf=0.
//   Reset applied mid-operation aborts it; no done pulse, outputs cleared.
// - States: IDLE -> RUN -> DONE -> IDLE.
// - IDLE: start=1 latches a, (sub ? ~b : b), and carry=c_in^sub; loads slice counter=0; -> RUN.
// - RUN: each cycle adds the low SLICE bits of the A/B shift registers plus carry, then:
//   updates carry, shifts the result slice into the MSB end of the partial-sum register,
//   and shifts A/B right by SLICE. Carry into the MSB is captured on the final slice.
//   After NSL RUN cycles -> DONE.
// - DONE (one cycle): s, c_out, ovf are loaded from the partial result; done=1; -> IDLE.
// - Timing: start high in cycle 0 -> busy=1 in cycles 1..NSL+1 -> done=1 and new s
//   visible in cycle NSL+1. busy and done fall in cycle NSL+2.
//   Back-to-back ops: the next start is accepted in cycle NSL+2 at the earliest.
// - start while busy is ignored; operand inputs may change freely after acceptance.
// - s/c_out/ovf never change except at completion or reset; they are stable while busy.
// - Width rules: result is modulo 2^WIDTH. Sub mode uses two's complement: a + ~b + (1-c_in).
// - Arithmetic is identical for all SLICE values; only latency differs.
// TESTING
// 1. WIDTH=8,SLICE=1: a=0xFF,b=0x01,c_in=0,sub=0 -> s=0x00,c_out=1,ovf=0; done in cycle 9.
// 2. a=0x7F,b=0x01,sub=0 -> s=0x80,c_out=0,ovf=1; then a=0x80,b=0x80 -> s=0x00,c_out=1,ovf=1.
// 3. sub=1: a=0x05,b=0x07,c_in=0 -> s=0xFE,c_out=0; a=0x07,b=0x05,c_in=1 -> s=0x01,c_out=1.
// 4. Start accepted, then start re-pulsed with new operands at cycle 3 -> ignored.
//    Single done pulse; s reflects the first operands.
// 5. rst asserted in cycle 4 of a run -> cycle 5: busy=0,s=0,no done; a fresh start completes normally.
// 6. WIDTH=8,SLICE=4: latency 3 cycles, and WIDTH=4 exhaustive over a,b,c_in,sub for SLICE in {1,2,4}.
//    Each case compared against a behavioural +/- model.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder/subtractor that adds SLICE bits per clock
// through a registered carry. An operation takes WIDTH/SLICE RUN cycles and one
// DONE cycle, and sits behind a start/busy/done handshake.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         operation request, sampled only while idle
//   sub           0: a+b+c_in, 1: a-b-c_in (c_in is borrow-in)
//   a, b, c_in    operands, latched when start is accepted
//   busy          high while an operation is in progress
//   done          one-cycle pulse when s/c_out/ovf have just been updated
//   s             registered result, held until the next completion
//   c_out         raw carry out of the MSB (sub mode: 1 = no borrow)
//   ovf           signed overflow (carry into MSB xor carry out of MSB)
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned SLICE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf
);

    localparam int unsigned NSL = WIDTH / SLICE;
    localparam int unsigned CW  = (NSL > 1) ? $clog2(NSL) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] ps;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             last_c;
    logic [SLICE-1:0] slice_sum_c;
    logic             slice_cout_c;
    logic             slice_cmsb_c;
    logic [WIDTH-1:0] ps_nxt_c;

    // One slice of the add, plus the partial-sum register shifted by one slice
    always_comb begin
        {slice_cout_c, slice_sum_c} = {1'b0, a_sr[SLICE-1:0]}
                                    + {1'b0, b_sr[SLICE-1:0]}
                                    + (SLICE+1)'(carry);
        // Carry into the slice MSB recovered from its sum bit and operand bits
        slice_cmsb_c = slice_sum_c[SLICE-1] ^ a_sr[SLICE-1] ^ b_sr[SLICE-1];
        ps_nxt_c     = (ps >> SLICE) | (WIDTH'(slice_sum_c) << (WIDTH - SLICE));
        last_c       = (cnt == CW'(NSL - 1));
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_c) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Datapath and registered outputs; results land on the final RUN edge so
    // they are visible during the DONE cycle together with the done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            c_out <= 1'b0;
            ovf   <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            ps    <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_nxt != IDLE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= sub ? ~b : b;
                        // Subtract is a + ~b + 1 - borrow_in
                        carry <= c_in ^ sub;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sr  <= a_sr >> SLICE;
                    b_sr  <= b_sr >> SLICE;
                    carry <= slice_cout_c;
                    ps    <= ps_nxt_c;
                    cnt   <= cnt + CW'(1);
                    if (last_c) begin
                        s     <= ps_nxt_c;
                        c_out <= slice_cout_c;
                        ovf   <= slice_cmsb_c ^ slice_cout_c;
                        done  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder. Instances: 8-bit/slice 1,
// 8-bit/slice 4, and 4-bit with slices 1, 2, 4 (shared operands, own starts).
module tb_serial_adder;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        int         due;
    } exp_t;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       busy;
        logic       done;
        int         due;
    } st_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0;
    logic       start84 = 1'b0;
    logic       start4 = 1'b0;
    logic       sub = 1'b0;
    logic       c_in = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;

    logic       busy8, done8, c8, v8;
    logic [7:0] s8;
    logic       busy84, done84, c84, v84;
    logic [7:0] s84;
    logic [2:0] busy4, done4, c4, v4;
    logic [3:0] s4 [3];

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   finishing = 1'b0;
    bit   summary_ready = 1'b0;

    exp_t q8[$];
    exp_t q84[$];
    exp_t q4 [3][$];
    st_t  st_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8), .SLICE(1)) u8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy8), .done(done8), .s(s8), .c_out(c8), .ovf(v8)
    );

    serial_adder #(.WIDTH(8), .SLICE(4)) u84 (
        .clk(clk), .rst(rst), .start(start84), .sub(sub), .a(a), .b(b), .c_in(c_in),
        .busy(busy84), .done(done84), .s(s84), .c_out(c84), .ovf(v84)
    );

    for (genvar g = 0; g < 3; g++) begin : gen_w4
        serial_adder #(.WIDTH(4), .SLICE(1 << g)) u4 (
            .clk(clk), .rst(rst), .start(start4), .sub(sub), .a(a[3:0]), .b(b[3:0]),
            .c_in(c_in), .busy(busy4[g]), .done(done4[g]), .s(s4[g]), .c_out(c4[g]),
            .ovf(v4[g])
        );
    end

    // Behavioural +/- reference: returns {ovf, c_out, s}
    function automatic logic [9:0] model(input int w, input int ai, input int bi,
                                         input int subi, input int cin);
        int mask, lm, bb, c, tot, low, cout, cm;
        mask = (1 << w) - 1;
        lm   = (1 << (w - 1)) - 1;
        bb   = (subi != 0) ? (~bi & mask) : (bi & mask);
        c    = (cin ^ subi) & 1;
        tot  = (ai & mask) + bb + c;
        low  = (ai & lm) + (bb & lm) + c;
        cout = (tot >> w) & 1;
        cm   = (low >> (w - 1)) & 1;
        return {1'((cm ^ cout) & 1), 1'(cout), 8'(tot & mask)};
    endfunction

    // Monitor: sole owner of the check/error counters
    exp_t e;
    st_t  st;
    logic [9:0] s8_prev;
    always @(negedge clk) begin
        if (done8) begin
            checks++;
            if (q8.size() == 0) begin
                errors++;
                $display("FAIL u8_unexpected_done cycle=%0d s=%h", cyc, s8);
            end else begin
                e = q8.pop_front();
                if (s8 !== e.s || c8 !== e.c || v8 !== e.v || cyc != e.due || busy8 !== 1'b1) begin
                    errors++;
                    $display("FAIL u8_result got s=%h c=%b v=%b cyc=%0d busy=%b want s=%h c=%b v=%b cyc=%0d busy=1",
                             s8, c8, v8, cyc, busy8, e.s, e.c, e.v, e.due);
                end
            end
        end
        if (done84) begin
            checks++;
            if (q84.size() == 0) begin
                errors++;
                $display("FAIL u84_unexpected_done cycle=%0d s=%h", cyc, s84);
            end else begin
                e = q84.pop_front();
                if (s84 !== e.s || c84 !== e.c || v84 !== e.v || cyc != e.due) begin
                    errors++;
                    $display("FAIL u84_result got s=%h c=%b v=%b cyc=%0d want s=%h c=%b v=%b cyc=%0d",
                             s84, c84, v84, cyc, e.s, e.c, e.v, e.due);
                end
            end
        end
        for (int g = 0; g < 3; g++) begin
            if (done4[g]) begin
                checks++;
                if (q4[g].size() == 0) begin
                    errors++;
                    $display("FAIL u4_slice%0d_unexpected_done cycle=%0d", 1 << g, cyc);
                end else begin
                    e = q4[g].pop_front();
                    if (s4[g] !== e.s[3:0] || c4[g] !== e.c || v4[g] !== e.v || cyc != e.due) begin
                        errors++;
                        $display("FAIL u4_slice%0d_result got s=%h c=%b v=%b cyc=%0d want s=%h c=%b v=%b cyc=%0d",
                                 1 << g, s4[g], c4[g], v4[g], cyc, e.s[3:0], e.c, e.v, e.due);
                    end
                end
            end
        end
        while (st_q.size() > 0 && st_q[0].due <= cyc) begin
            st = st_q.pop_front();
            checks++;
            if (s8 !== st.s || c8 !== st.c || v8 !== st.v || busy8 !== st.busy || done8 !== st.done) begin
                errors++;
                $display("FAIL u8_status cyc=%0d got s=%h c=%b v=%b busy=%b done=%b want s=%h c=%b v=%b busy=%b done=%b",
                         cyc, s8, c8, v8, busy8, done8, st.s, st.c, st.v, st.busy, st.done);
            end
        end
        // Results must hold while an operation is in flight
        if (busy8 && !done8) begin
            checks++;
            if ({v8, c8, s8} !== s8_prev) begin
                errors++;
                $display("FAIL u8_hold cyc=%0d got %h want %h", cyc, {v8, c8, s8}, s8_prev);
            end
        end
        s8_prev = {v8, c8, s8};
        if (finishing && !summary_ready) begin
            checks++;
            if (q8.size() != 0 || q84.size() != 0 || st_q.size() != 0 ||
                q4[0].size() != 0 || q4[1].size() != 0 || q4[2].size() != 0) begin
                errors++;
                $display("FAIL pending_results got q8=%0d q84=%0d st=%0d q4=%0d/%0d/%0d want all 0",
                         q8.size(), q84.size(), st_q.size(), q4[0].size(), q4[1].size(), q4[2].size());
            end
            summary_ready = 1'b1;
        end
    end

    // Pulse one start for a cycle, then scramble operands to prove they were latched
    task automatic drive(input int which, input logic [7:0] ta, input logic [7:0] tbv,
                         input logic tsub, input logic tcin);
        a = ta; b = tbv; sub = tsub; c_in = tcin;
        if (which == 0) start8 = 1'b1;
        else if (which == 1) start84 = 1'b1;
        else start4 = 1'b1;
        @(negedge clk);
        start8 = 1'b0; start84 = 1'b0; start4 = 1'b0;
        a = ~ta; b = ~tbv; sub = ~tsub; c_in = ~tcin;
    endtask

    task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tsub,
                       input logic tcin, input logic [7:0] es, input logic ec, input logic ev);
        q8.push_back('{s: es, c: ec, v: ev, due: cyc + 9});
        drive(0, ta, tbv, tsub, tcin);
        repeat (9) @(negedge clk);
    endtask

    task automatic op84(input logic [7:0] ta, input logic [7:0] tbv, input logic tsub,
                        input logic tcin, input logic [7:0] es, input logic ec, input logic ev);
        q84.push_back('{s: es, c: ec, v: ev, due: cyc + 3});
        drive(1, ta, tbv, tsub, tcin);
        repeat (3) @(negedge clk);
    endtask

    logic [9:0] m;
    int c0;
    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        st_q.push_back('{s: 8'h00, c: 1'b0, v: 1'b0, busy: 1'b0, done: 1'b0, due: cyc + 1});
        @(negedge clk);
        @(negedge clk);

        // Carry out of the top, then done/busy must have fallen in cycle NSL+2
        st_q.push_back('{s: 8'h00, c: 1'b1, v: 1'b0, busy: 1'b0, done: 1'b0, due: cyc + 10});
        op8(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op8(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
        op8(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op8(8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);
        op8(8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // Start re-pulsed mid-run must be ignored; old result held while busy
        c0 = cyc;
        st_q.push_back('{s: 8'h00, c: 1'b1, v: 1'b0, busy: 1'b1, done: 1'b0, due: c0 + 5});
        q8.push_back('{s: 8'h46, c: 1'b0, v: 1'b0, due: c0 + 9});
        drive(0, 8'h12, 8'h34, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        drive(0, 8'hFF, 8'hFF, 1'b1, 1'b1);
        repeat (12) @(negedge clk);

        // Reset in cycle 4 of a run aborts it with no done pulse
        c0 = cyc;
        drive(0, 8'h33, 8'h44, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        st_q.push_back('{s: 8'h00, c: 1'b0, v: 1'b0, busy: 1'b0, done: 1'b0, due: c0 + 5});
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        op8(8'h33, 8'h44, 1'b0, 1'b1, 8'h78, 1'b0, 1'b0);

        // Four bits per clock: same arithmetic, three-cycle latency
        op84(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        op84(8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0);
        op84(8'hAA, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        op84(8'h07, 8'h05, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0);

        // 4-bit exhaustive sweep across all slice widths
        for (int ia = 0; ia < 16; ia++)
            for (int ib = 0; ib < 16; ib++)
                for (int is = 0; is < 2; is++)
                    for (int ic = 0; ic < 2; ic++) begin
                        m = model(4, ia, ib, is, ic);
                        q4[0].push_back('{s: m[7:0], c: m[8], v: m[9], due: cyc + 5});
                        q4[1].push_back('{s: m[7:0], c: m[8], v: m[9], due: cyc + 3});
                        q4[2].push_back('{s: m[7:0], c: m[8], v: m[9], due: cyc + 2});
                        drive(2, 8'(ia), 8'(ib), 1'(is), 1'(ic));
                        repeat (5) @(negedge clk);
                    end

        finishing = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
